// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the scan decoder family.
//   state_t    : decoder FSM states (IDLE, DRIVE, GAP)
//   MODE_*     : values of the MODE input
//   onehot_l() : active-low one-hot vector for a line index, valid for up to
//                MAX_LINES outputs; callers size-cast the result to their N.
// ---------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_LINES = 64;

    // Index outside 0..width-1 yields an all-high vector, so an out-of-range
    // request can never pull a line low.
    function automatic logic [MAX_LINES-1:0] onehot_l(input int idx, input int width);
        logic [MAX_LINES-1:0] vec;
        vec = '1;
        if (idx >= 0 && idx < width && idx < MAX_LINES) begin
            vec = ~(MAX_LINES'(1) << idx);
        end
        return vec;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
// Terminal-count counter running 0..TERM-1 while enabled. done is high on
// the cycle the count sits at TERM-1 with enable high; the counter then
// rolls back to 0 on that edge. clear has priority over enable.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset (count to 0)
//   clear  : synchronous clear to 0
//   enable : advance the count
//   done   : terminal count reached this cycle
// ---------------------------------------------------------------------------
module dwell_timer
    import decoder_pkg::*;
#(
    parameter int TERM = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = (TERM > 1) ? $clog2(TERM) : 1;
    localparam int LAST  = (TERM > 0) ? TERM - 1 : 0;

    logic [CNT_W-1:0] count;

    assign done = enable && (count == CNT_W'(LAST));

    // Count register: equality compare at LAST means it never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= done ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// ---------------------------------------------------------------------------
// scan_decoder
// Registered SEL_W-to-2^SEL_W active-low decoder with enable G_L,
// break-before-make blanking (BLANK all-high cycles on every line change)
// and an optional auto-scan mode dwelling DIV cycles on each line.
// Build option: SCAN_DECODER_SCAN_EN enables scan mode, the dwell counter
// and WRAP; without it MODE is treated as direct and WRAP is tied 0.
// Ports:
//   CLK   : rising-edge clock
//   RESET : asynchronous active-high reset
//   G_L   : active-low enable; high forces IDLE with all lines high
//   MODE  : 0 = direct decode of SEL, 1 = auto-scan
//   SEL   : line select in direct mode
//   Y_L   : registered active-low one-hot outputs
//   IDX   : registered index of current / most recent driven line
//   WRAP  : one-cycle pulse when a scan advance wraps N-1 to 0
// ---------------------------------------------------------------------------
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  G_L,
    input  logic                  MODE,
    input  logic [SEL_W-1:0]      SEL,
    output logic [(2**SEL_W)-1:0] Y_L,
    output logic [SEL_W-1:0]      IDX,
    output logic                  WRAP
);

    localparam int N = 2**SEL_W;

    state_t           state_q, state_d;
    logic [N-1:0]     y_q, y_d;
    logic [SEL_W-1:0] idx_q, idx_d, next_line;
    logic             cur_mode_q, cur_mode_d;
    logic             gap_hold_q, gap_hold_d;
    logic             wrap_q, wrap_d;
    logic             load;
    logic             mode_in;
    logic             dwell_done;
    logic             gap_en, gap_done;

    // Gap counter only runs while blanking and enabled; any other state
    // leaves it cleared so each gap starts from 0.
    assign gap_en = (state_q == GAP) && !G_L;

    dwell_timer #(.TERM(BLANK)) u_gap (
        .clk    (CLK),
        .rst    (RESET),
        .clear  (!gap_en),
        .enable (gap_en),
        .done   (gap_done)
    );

`ifdef SCAN_DECODER_SCAN_EN
    logic dwell_en;

    assign mode_in = MODE;

    // Dwell only counts while driving in a stable scan mode; a pending mode
    // change or leaving DRIVE clears it so the next dwell restarts at 0.
    assign dwell_en = (state_q == DRIVE) && !G_L &&
                      (mode_in == MODE_SCAN) && (cur_mode_q == MODE_SCAN);

    dwell_timer #(.TERM(DIV)) u_dwell (
        .clk    (CLK),
        .rst    (RESET),
        .clear  (!dwell_en),
        .enable (dwell_en),
        .done   (dwell_done)
    );

    assign WRAP = wrap_q;
`else
    logic unused_cfg;

    assign mode_in    = MODE_DIRECT;
    assign dwell_done = 1'b0;
    assign WRAP       = 1'b0;
    assign unused_cfg = ^{MODE, wrap_q, 32'(DIV)};
`endif

    // Next-state and output decode. cur_mode_q is the mode the current
    // line was driven in; a mismatch with mode_in is a mode change.
    // gap_hold_q marks a gap caused by a mode change, after which a scan
    // resumes on the same line instead of advancing. With BLANK=0 every
    // gap-end action happens on the edge that would have entered GAP.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        idx_d      = idx_q;
        cur_mode_d = cur_mode_q;
        gap_hold_d = gap_hold_q;
        wrap_d     = 1'b0;
        load       = 1'b0;
        next_line  = idx_q;

        if (G_L) begin
            state_d = IDLE;
            y_d     = '1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = DRIVE;
                    cur_mode_d = mode_in;
                    gap_hold_d = 1'b0;
                    load       = 1'b1;
                    next_line  = (mode_in == MODE_SCAN) ? '0 : SEL;
                end
                DRIVE: begin
                    if (mode_in != cur_mode_q) begin
                        if (BLANK == 0) begin
                            cur_mode_d = mode_in;
                            load       = 1'b1;
                            next_line  = (mode_in == MODE_DIRECT) ? SEL : idx_q;
                        end else begin
                            state_d    = GAP;
                            y_d        = '1;
                            gap_hold_d = 1'b1;
                        end
                    end else if (cur_mode_q == MODE_DIRECT) begin
                        if (SEL != idx_q) begin
                            if (BLANK == 0) begin
                                load      = 1'b1;
                                next_line = SEL;
                            end else begin
                                state_d    = GAP;
                                y_d        = '1;
                                gap_hold_d = 1'b0;
                            end
                        end
                    end else if (dwell_done) begin
                        if (BLANK == 0) begin
                            load      = 1'b1;
                            next_line = idx_q + SEL_W'(1);
                            wrap_d    = (idx_q == SEL_W'(N - 1));
                        end else begin
                            state_d    = GAP;
                            y_d        = '1;
                            gap_hold_d = 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state_d    = DRIVE;
                        cur_mode_d = mode_in;
                        load       = 1'b1;
                        if (mode_in == MODE_DIRECT) begin
                            next_line = SEL;
                        end else if (cur_mode_q == MODE_SCAN && !gap_hold_q) begin
                            next_line = idx_q + SEL_W'(1);
                            wrap_d    = (idx_q == SEL_W'(N - 1));
                        end else begin
                            next_line = idx_q;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    y_d     = '1;
                end
            endcase

            if (load) begin
                idx_d = next_line;
                y_d   = N'(onehot_l(int'(next_line), N));
            end
        end
    end

    // State and output registers; reset blanks every line at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            y_q        <= '1;
            idx_q      <= '0;
            cur_mode_q <= MODE_DIRECT;
            gap_hold_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            idx_q      <= idx_d;
            cur_mode_q <= cur_mode_d;
            gap_hold_q <= gap_hold_d;
            wrap_q     <= wrap_d;
        end
    end

    assign Y_L = y_q;
    assign IDX = idx_q;

endmodule

// File: tb/tb_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_scan_decoder
// Drives two scan_decoder instances (BLANK=1 and BLANK=0, SEL_W=2, DIV=4)
// with identical inputs and checks both against expected values.
// ---------------------------------------------------------------------------
module tb_scan_decoder;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       G_L;
    logic       MODE;
    logic [1:0] SEL;

    logic [3:0] y1, y0;
    logic [1:0] idx1, idx0;
    logic       w1, w0;

    scan_decoder #(.SEL_W(2), .DIV(4), .BLANK(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .G_L(G_L), .MODE(MODE), .SEL(SEL),
        .Y_L(y1), .IDX(idx1), .WRAP(w1)
    );

    scan_decoder #(.SEL_W(2), .DIV(4), .BLANK(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .G_L(G_L), .MODE(MODE), .SEL(SEL),
        .Y_L(y0), .IDX(idx0), .WRAP(w0)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       g_l;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] y1;
        logic [1:0] idx1;
        logic [3:0] y0;
        logic [1:0] idx0;
    } vec_t;

    typedef struct {
        logic [3:0] y1;
        logic [1:0] idx1;
        logic       w1;
        logic [3:0] y0;
        logic [1:0] idx0;
        logic       w0;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    function automatic exp_t mkExp(input logic [3:0] ey1, input logic [1:0] ei1, input logic ew1,
                                   input logic [3:0] ey0, input logic [1:0] ei0, input logic ew0);
        exp_t e;
        e.y1 = ey1; e.idx1 = ei1; e.w1 = ew1;
        e.y0 = ey0; e.idx0 = ei0; e.w0 = ew0;
        return e;
    endfunction

    // Expected scan outputs t edges after entering scan from IDLE:
    // BLANK=1 gives a 5-cycle line period (4 low, 1 gap), BLANK=0 gives 4.
    function automatic exp_t scanExpect(input int t);
        int line1, line0;
        logic [3:0] ey1, ey0;
        line1 = (t / 5) % 4;
        line0 = (t / 4) % 4;
        ey1 = ((t % 5) < 4) ? ~(4'b0001 << line1) : 4'hF;
        ey0 = ~(4'b0001 << line0);
        return mkExp(ey1, 2'(line1), (t > 0) && (t % 20 == 0),
                     ey0, 2'(line0), (t > 0) && (t % 16 == 0));
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic checkScoreboard(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL %s: scoreboard empty, got y1=%0h required an entry", tag, y1);
            return;
        end
        e = sb.pop_front();
        checkOutput($sformatf("%s dut1 Y_L", tag),  8'(y1),   8'(e.y1));
        checkOutput($sformatf("%s dut1 IDX", tag),  8'(idx1), 8'(e.idx1));
        checkOutput($sformatf("%s dut1 WRAP", tag), 8'(w1),   8'(e.w1));
        checkOutput($sformatf("%s dut0 Y_L", tag),  8'(y0),   8'(e.y0));
        checkOutput($sformatf("%s dut0 IDX", tag),  8'(idx0), 8'(e.idx0));
        checkOutput($sformatf("%s dut0 WRAP", tag), 8'(w0),   8'(e.w0));
    endtask

    // Drive one set of inputs, queue what the edge should produce, then
    // sample one time unit after that edge.
    task automatic applyStimulus(input logic g, input logic m, input logic [1:0] s,
                                 input exp_t e, input string tag);
        G_L  = g;
        MODE = m;
        SEL  = s;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        checkScoreboard(tag);
    endtask

    task automatic scanRun(input int n, input string tag);
        for (int t = 0; t < n; t++) begin
            applyStimulus(1'b0, 1'b1, 2'(t), scanExpect(t), $sformatf("%s t%0d", tag, t));
        end
    endtask

    task automatic runTable(input logic force_scan, input string tag);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].g_l, force_scan ? 1'b1 : vecs[i].mode, vecs[i].sel,
                          mkExp(vecs[i].y1, vecs[i].idx1, 1'b0, vecs[i].y0, vecs[i].idx0, 1'b0),
                          $sformatf("%s%0d", tag, i));
        end
    endtask

    task automatic checkAsyncReset();
        checkOutput("areset dut1 Y_L",  8'(y1),   8'h0F);
        checkOutput("areset dut1 IDX",  8'(idx1), 8'h00);
        checkOutput("areset dut1 WRAP", 8'(w1),   8'h00);
        checkOutput("areset dut0 Y_L",  8'(y0),   8'h0F);
        checkOutput("areset dut0 IDX",  8'(idx0), 8'h00);
        checkOutput("areset dut0 WRAP", 8'(w0),   8'h00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RESET = 1'b1;
        G_L   = 1'b1;
        MODE  = 1'b0;
        SEL   = 2'd0;

        // Direct-mode table: {G_L, MODE, SEL, Y_L/IDX for BLANK=1, for BLANK=0}
        vecs[0]  = '{1'b0, 1'b0, 2'd2, 4'hB, 2'd2, 4'hB, 2'd2};
        vecs[1]  = '{1'b0, 1'b0, 2'd1, 4'hF, 2'd2, 4'hD, 2'd1};
        vecs[2]  = '{1'b0, 1'b0, 2'd1, 4'hD, 2'd1, 4'hD, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 4'hF, 2'd1, 4'hE, 2'd0};
        vecs[4]  = '{1'b0, 1'b0, 2'd3, 4'h7, 2'd3, 4'h7, 2'd3};
        vecs[5]  = '{1'b0, 1'b0, 2'd3, 4'h7, 2'd3, 4'h7, 2'd3};
        vecs[6]  = '{1'b1, 1'b0, 2'd3, 4'hF, 2'd3, 4'hF, 2'd3};
        vecs[7]  = '{1'b1, 1'b0, 2'd0, 4'hF, 2'd3, 4'hF, 2'd3};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 4'hE, 2'd0, 4'hE, 2'd0};
        vecs[9]  = '{1'b0, 1'b0, 2'd1, 4'hF, 2'd0, 4'hD, 2'd1};
        vecs[10] = '{1'b0, 1'b0, 2'd2, 4'hB, 2'd2, 4'hB, 2'd2};
        vecs[11] = '{1'b0, 1'b0, 2'd3, 4'hF, 2'd2, 4'h7, 2'd3};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 4'hE, 2'd0, 4'hE, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 4'hE, 2'd0, 4'hE, 2'd0};
        vecs[14] = '{1'b1, 1'b0, 2'd1, 4'hF, 2'd0, 4'hF, 2'd0};

        #12;
        checkOutput("reset dut1 Y_L",  8'(y1),   8'h0F);
        checkOutput("reset dut1 IDX",  8'(idx1), 8'h00);
        checkOutput("reset dut1 WRAP", 8'(w1),   8'h00);
        checkOutput("reset dut0 Y_L",  8'(y0),   8'h0F);
        checkOutput("reset dut0 IDX",  8'(idx0), 8'h00);
        checkOutput("reset dut0 WRAP", 8'(w0),   8'h00);
        RESET = 1'b0;

        runTable(1'b0, "vec");

`ifdef SCAN_DECODER_SCAN_EN
        scanRun(43, "scan");
        // Enable pulsed high mid-dwell, then a fresh scan from line 0.
        applyStimulus(1'b1, 1'b1, 2'd0, mkExp(4'hF, 2'd0, 1'b0, 4'hF, 2'd2, 1'b0), "gpulse");
        scanRun(23, "rescan");
        // Scan to direct mid-dwell with SEL=3.
        applyStimulus(1'b0, 1'b0, 2'd3, mkExp(4'hF, 2'd0, 1'b0, 4'h7, 2'd3, 1'b0), "mode0 a");
        applyStimulus(1'b0, 1'b0, 2'd3, mkExp(4'h7, 2'd3, 1'b0, 4'h7, 2'd3, 1'b0), "mode0 b");
        applyStimulus(1'b1, 1'b1, 2'd0, mkExp(4'hF, 2'd3, 1'b0, 4'hF, 2'd3, 1'b0), "disable");
        scanRun(12, "prereset");
`else
        // Without scan support MODE=1 must decode exactly as direct mode.
        runTable(1'b1, "m1vec");
        applyStimulus(1'b0, 1'b1, 2'd2, mkExp(4'hB, 2'd2, 1'b0, 4'hB, 2'd2, 1'b0), "prereset");
`endif

        // Asynchronous reset between edges, then release before the next edge.
        #2;
        RESET = 1'b1;
        #1;
        checkAsyncReset();
        #2;
        RESET = 1'b0;

`ifdef SCAN_DECODER_SCAN_EN
        scanRun(3, "postreset");
`else
        applyStimulus(1'b0, 1'b1, 2'd1, mkExp(4'hD, 2'd1, 1'b0, 4'hD, 2'd1, 1'b0), "postreset");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
